// File: rtl/fifo_lvl.sv
// Show-ahead synchronous FIFO with occupancy level, programmable almost-full/almost-empty flags,
// sticky overflow/underflow flags and a synchronous flush; all state changes on the falling clock edge.
module fifo_lvl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int AF_TH  = 12,
  parameter int AE_TH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              wr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              rd,
  output logic [DATA_W-1:0] r_data,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AF_L    = AF_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_L    = AE_TH[ADDR_W:0];

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] w_ptr_q, w_ptr_d;
  logic [ADDR_W-1:0] r_ptr_q, r_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              ae_q, ae_d;
  logic              af_q, af_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              wr_ok, rd_ok;

  // A simultaneous read frees the slot, so a write into a full FIFO is still accepted.
  assign wr_ok = wr & (~full_q | rd);
  assign rd_ok = rd & ~empty_q;

  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (flush) begin
      w_ptr_d = '0;
      r_ptr_d = '0;
      level_d = '0;
    end else begin
      if (wr_ok) w_ptr_d = w_ptr_q + ADDR_W'(1);
      if (rd_ok) r_ptr_d = r_ptr_q + ADDR_W'(1);
      case ({wr_ok, rd_ok})
        2'b10:   level_d = level_q + (ADDR_W+1)'(1);
        2'b01:   level_d = level_q - (ADDR_W+1)'(1);
        default: level_d = level_q;
      endcase
      ovf_d = (wr & full_q & ~rd) | (ovf_q & ~clr_err);
      udf_d = (rd & empty_q) | (udf_q & ~clr_err);
    end
    empty_d = (level_d == '0);
    full_d  = (level_d == DEPTH_L);
    ae_d    = (level_d <= AE_L);
    af_d    = (level_d >= AF_L);
  end

  always_ff @(negedge clk) begin
    if (!reset) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ae_q    <= 1'b1;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      level_q <= level_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ae_q    <= ae_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage is deliberately left uncleared by reset and flush.
  always_ff @(negedge clk) begin
    if (reset && !flush && wr_ok) mem[w_ptr_q] <= w_data;
  end

  assign r_data       = mem[r_ptr_q];
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = ae_q;
  assign almost_full  = af_q;
  assign level        = level_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_lvl.sv
// Bench for fifo_lvl (DEPTH=4, AF_TH=3, AE_TH=1): vector table, directed corner sequences and
// random traffic checked against a queue-based reference model.
module tb_fifo_lvl;

  logic       clk = 1'b0;
  logic       reset = 1'b0, flush = 1'b0, wr = 1'b0, rd = 1'b0, clr_err = 1'b0;
  logic [7:0] w_data = 8'h00;
  logic [7:0] r_data;
  logic       empty, full, almost_empty, almost_full, overflow, underflow;
  logic [2:0] level;

  int checks = 0;
  int failures = 0;

  logic [7:0] mq[$];
  logic       m_ov = 1'b0, m_un = 1'b0;

  fifo_lvl #(.DATA_W(8), .ADDR_W(2), .AF_TH(3), .AE_TH(1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .wr(wr), .w_data(w_data), .rd(rd),
    .r_data(r_data), .empty(empty), .full(full), .almost_empty(almost_empty),
    .almost_full(almost_full), .level(level), .overflow(overflow),
    .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: a bounded queue of capacity 4 with sticky error bits.
  task automatic model_step(input logic rs, fl, w, r, ce, input logic [7:0] d);
    int n;
    logic ovs, uns;
    logic [7:0] junk;
    n = mq.size();
    if (!rs) begin
      mq.delete(); m_ov = 1'b0; m_un = 1'b0;
    end else if (fl) begin
      mq.delete();
    end else begin
      ovs = w && (n == 4) && !r;
      uns = r && (n == 0);
      if (r && n > 0) junk = mq.pop_front();
      if (w && (n < 4 || r)) mq.push_back(d);
      m_ov = ovs || (m_ov && !ce);
      m_un = uns || (m_un && !ce);
    end
  endtask

  task automatic cmp_model();
    int n;
    n = mq.size();
    chk("m_level", 32'(level), 32'(n));
    chk("m_empty", 32'(empty), 32'(n == 0));
    chk("m_full", 32'(full), 32'(n == 4));
    chk("m_aempty", 32'(almost_empty), 32'(n <= 1));
    chk("m_afull", 32'(almost_full), 32'(n >= 3));
    chk("m_overflow", 32'(overflow), 32'(m_ov));
    chk("m_underflow", 32'(underflow), 32'(m_un));
    if (n > 0) chk("m_rdata", 32'(r_data), 32'(mq[0]));
  endtask

  // Inputs change just after the rising edge; state moves on the falling edge; outputs are
  // sampled just after the following rising edge.
  task automatic cyc(input logic rs, fl, w, r, ce, input logic [7:0] d);
    reset = rs; flush = fl; wr = w; rd = r; clr_err = ce; w_data = d;
    @(negedge clk);
    model_step(rs, fl, w, r, ce, d);
    @(posedge clk);
    #1;
    cmp_model();
  endtask

  typedef struct {
    logic       rs, fl, w, r, ce;
    logic [7:0] d;
    int         lvl;
    logic       e, f, ae, af, ov, un, cd;
    logic [7:0] rdv;
  } vec_t;

  vec_t tbl[13];
  logic [7:0] exp_head[6];

  initial begin
    tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,8'h00, 0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,8'h00};
    tbl[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,8'h00, 0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,8'h00};
    tbl[2]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,8'h00, 0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,8'h00};
    tbl[3]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,8'hA1, 1, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1,8'hA1};
    tbl[4]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,8'hA2, 2, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,8'hA1};
    tbl[5]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,8'hA3, 3, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b1,8'hA1};
    tbl[6]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,8'hA4, 4, 1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 1'b1,8'hA1};
    tbl[7]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,8'hB5, 4, 1'b0,1'b1,1'b0,1'b1,1'b1,1'b0, 1'b1,8'hA1};
    tbl[8]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,8'h00, 3, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 1'b1,8'hA2};
    tbl[9]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,8'h00, 2, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,8'hA3};
    tbl[10] = '{1'b1,1'b0,1'b0,1'b1,1'b0,8'h00, 1, 1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 1'b1,8'hA4};
    tbl[11] = '{1'b1,1'b0,1'b0,1'b1,1'b0,8'h00, 0, 1'b1,1'b0,1'b1,1'b0,1'b1,1'b0, 1'b0,8'h00};
    tbl[12] = '{1'b1,1'b0,1'b0,1'b0,1'b1,8'h00, 0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,8'h00};

    @(posedge clk);
    #1;
    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].rs, tbl[i].fl, tbl[i].w, tbl[i].r, tbl[i].ce, tbl[i].d);
      chk("t_level", 32'(level), 32'(tbl[i].lvl));
      chk("t_empty", 32'(empty), 32'(tbl[i].e));
      chk("t_full", 32'(full), 32'(tbl[i].f));
      chk("t_aempty", 32'(almost_empty), 32'(tbl[i].ae));
      chk("t_afull", 32'(almost_full), 32'(tbl[i].af));
      chk("t_overflow", 32'(overflow), 32'(tbl[i].ov));
      chk("t_underflow", 32'(underflow), 32'(tbl[i].un));
      if (tbl[i].cd) chk("t_rdata", 32'(r_data), 32'(tbl[i].rdv));
    end

    // Steady level 3 with simultaneous read/write across pointer wrap.
    cyc(1, 0, 1, 0, 0, 8'hF0);
    cyc(1, 0, 1, 0, 0, 8'hF1);
    cyc(1, 0, 1, 0, 0, 8'hF2);
    exp_head = '{8'hF0, 8'hF1, 8'hF2, 8'hC0, 8'hC1, 8'hC2};
    for (int i = 0; i < 6; i++) begin
      chk("wrap_head", 32'(r_data), 32'(exp_head[i]));
      cyc(1, 0, 1, 1, 0, 8'hC0 + 8'(i));
      chk("wrap_level", 32'(level), 32'd3);
    end

    // Read+write on a full FIFO, then on an empty one.
    cyc(1, 0, 1, 0, 0, 8'h60);
    chk("full_before_rw", 32'(full), 32'd1);
    cyc(1, 0, 1, 1, 0, 8'hD7);
    chk("full_rw_level", 32'(level), 32'd4);
    chk("full_rw_ovf", 32'(overflow), 32'd0);
    chk("full_rw_head", 32'(r_data), 32'h0C4);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 0, 8'h00);
    cyc(1, 0, 1, 1, 0, 8'hE9);
    chk("empty_rw_level", 32'(level), 32'd1);
    chk("empty_rw_rdata", 32'(r_data), 32'h0E9);
    chk("empty_rw_udf", 32'(underflow), 32'd1);

    // A set condition outranks clr_err on the same edge.
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 0, 8'h70 + 8'(i));
    cyc(1, 0, 1, 0, 0, 8'h7F);
    chk("ovf_set", 32'(overflow), 32'd1);
    cyc(1, 0, 1, 0, 1, 8'h7E);
    chk("clr_vs_set_ovf", 32'(overflow), 32'd1);
    chk("clr_vs_set_udf", 32'(underflow), 32'd0);
    cyc(1, 0, 0, 0, 1, 8'h00);
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_udf", 32'(underflow), 32'd0);

    // Flush keeps error flags and drops a concurrent write; reset clears everything.
    cyc(1, 0, 1, 0, 0, 8'h81);
    cyc(1, 0, 0, 1, 0, 8'h00);
    chk("pre_flush_level", 32'(level), 32'd3);
    cyc(1, 1, 1, 0, 0, 8'h82);
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_ovf_held", 32'(overflow), 32'd1);
    cyc(1, 0, 1, 0, 0, 8'h83);
    chk("post_flush_head", 32'(r_data), 32'h083);
    cyc(1, 0, 1, 0, 0, 8'h84);
    cyc(0, 0, 1, 0, 0, 8'h85);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_aempty", 32'(almost_empty), 32'd1);
    chk("rst_ovf", 32'(overflow), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(63) != 0), ($urandom_range(31) == 0), 1'($urandom_range(1)),
          1'($urandom_range(1)), ($urandom_range(15) == 0), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
